// File: rtl/uart_spi_bridge.sv
// ============================================================================
// uart_spi_bridge
// ----------------------------------------------------------------------------
// This block turns short UART command sequences into 16-bit SPI transactions.
// It answers every completed command with exactly one UART response byte.
//
//   'W' addr data -> SPI write of {addr & ~READ_FLAG, data}; response 'K' (4B)
//   'R' addr      -> SPI read of  {addr |  READ_FLAG, 00};   response = SPI byte
//   'P'           -> response 'P' (50)
//   other opcode  -> response '?' (3F) and an o_err pulse
//
// Optional feature (compile-time macro UART_SPI_BRIDGE_TIMEOUT_EN):
//   An inter-byte timeout for GET_ADDR / GET_DATA. When the timeout expires,
//   the block returns to IDLE, pulses o_err and sends no response. When the
//   macro is undefined, those states wait forever and no counter is built.
//
// Parameters
//   TIMEOUT_CYCLES  inter-byte timeout in i_clock cycles
//   READ_FLAG       mask ORed into the address byte for SPI reads
//   CMD_WRITE/CMD_READ/CMD_PING  opcodes
//
// Ports
//   i_clock, i_reset      system clock, synchronous active-high reset
//   i_rx_dv, i_rx_byte    received UART byte strobe and data
//   o_tx_dv, o_tx_byte    UART transmit start strobe and byte
//   i_tx_done, i_tx_active  UART transmitter completion strobe and busy level
//   o_spi_start           SPI transaction start strobe
//   o_spi_upper/lower     SPI address / data bytes
//   i_spi_busy, i_spi_done, i_spi_rx  SPI master busy, completion, read data
//   o_busy                high whenever the FSM is not in IDLE
//   o_err                 one-cycle protocol error strobe
// ============================================================================
module uart_spi_bridge #(
    parameter int          TIMEOUT_CYCLES = 43400,
    parameter logic [7:0]  READ_FLAG      = 8'h80,
    parameter logic [7:0]  CMD_WRITE      = 8'h57,
    parameter logic [7:0]  CMD_READ       = 8'h52,
    parameter logic [7:0]  CMD_PING       = 8'h50
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_done,
    input  logic       i_tx_active,
    output logic       o_spi_start,
    output logic [7:0] o_spi_upper,
    output logic [7:0] o_spi_lower,
    input  logic       i_spi_busy,
    input  logic       i_spi_done,
    input  logic [7:0] i_spi_rx,
    output logic       o_busy,
    output logic       o_err
);

    localparam logic [7:0] RESP_PING    = 8'h50;
    localparam logic [7:0] RESP_UNKNOWN = 8'h3F;
    localparam logic [7:0] RESP_WRITE   = 8'h4B;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        SPI_START,
        SPI_WAIT,
        TX_START,
        TX_WAIT
    } state_t;

    state_t state;
    logic   is_read;
    logic   timeout_hit;
    logic   in_addr_data;
    logic   in_locked;

    assign in_addr_data = (state == GET_ADDR) || (state == GET_DATA);

    // States in which a new UART byte cannot be accepted and is dropped.
    assign in_locked = (state == SPI_START) || (state == SPI_WAIT) ||
                       (state == TX_START)  || (state == TX_WAIT);

    assign o_busy = (state != IDLE);

`ifdef UART_SPI_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] timeout_cnt;

    // The timeout fires only in a cycle without a byte, so a byte that
    // arrives exactly at the limit still wins.
    assign timeout_hit = in_addr_data && (timeout_cnt == CNT_MAX) && !i_rx_dv;

    // Inter-byte counter: it restarts on every received byte and outside the
    // byte-collection states. It saturates so it can never wrap.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_rx_dv || !in_addr_data) begin
            timeout_cnt <= '0;
        end else if (timeout_cnt != CNT_MAX) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Main command FSM with registered strobes.
    // Each start strobe is raised on the edge that enters its *_START state
    // when the peer was idle on that edge. The strobe is therefore high
    // during the first cycle in that state. Otherwise it is raised on the
    // first later edge that sees the peer idle. Leaving the state always
    // clears the strobe, so it lasts one cycle and the two strobes can never
    // overlap.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            is_read     <= 1'b0;
            o_tx_dv     <= 1'b0;
            o_tx_byte   <= 8'h00;
            o_spi_start <= 1'b0;
            o_spi_upper <= 8'h00;
            o_spi_lower <= 8'h00;
            o_err       <= 1'b0;
        end else begin
            o_err <= 1'b0;

            if (i_rx_dv && in_locked) begin
                o_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_rx_dv) begin
                        if ((i_rx_byte == CMD_WRITE) || (i_rx_byte == CMD_READ)) begin
                            is_read <= (i_rx_byte == CMD_READ);
                            state   <= GET_ADDR;
                        end else if (i_rx_byte == CMD_PING) begin
                            o_tx_byte <= RESP_PING;
                            o_tx_dv   <= !i_tx_active;
                            state     <= TX_START;
                        end else begin
                            o_tx_byte <= RESP_UNKNOWN;
                            o_tx_dv   <= !i_tx_active;
                            o_err     <= 1'b1;
                            state     <= TX_START;
                        end
                    end
                end

                GET_ADDR: begin
                    if (timeout_hit) begin
                        o_err <= 1'b1;
                        state <= IDLE;
                    end else if (i_rx_dv) begin
                        if (is_read) begin
                            o_spi_upper <= i_rx_byte | READ_FLAG;
                            o_spi_lower <= 8'h00;
                            o_spi_start <= !i_spi_busy;
                            state       <= SPI_START;
                        end else begin
                            o_spi_upper <= i_rx_byte & ~READ_FLAG;
                            state       <= GET_DATA;
                        end
                    end
                end

                GET_DATA: begin
                    if (timeout_hit) begin
                        o_err <= 1'b1;
                        state <= IDLE;
                    end else if (i_rx_dv) begin
                        o_spi_lower <= i_rx_byte;
                        o_spi_start <= !i_spi_busy;
                        state       <= SPI_START;
                    end
                end

                SPI_START: begin
                    if (o_spi_start) begin
                        o_spi_start <= 1'b0;
                        state       <= SPI_WAIT;
                    end else if (!i_spi_busy) begin
                        o_spi_start <= 1'b1;
                    end
                end

                SPI_WAIT: begin
                    if (i_spi_done) begin
                        o_tx_byte <= is_read ? i_spi_rx : RESP_WRITE;
                        o_tx_dv   <= !i_tx_active;
                        state     <= TX_START;
                    end
                end

                TX_START: begin
                    if (o_tx_dv) begin
                        o_tx_dv <= 1'b0;
                        state   <= TX_WAIT;
                    end else if (!i_tx_active) begin
                        o_tx_dv <= 1'b1;
                    end
                end

                TX_WAIT: begin
                    if (i_tx_done) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    o_tx_dv     <= 1'b0;
                    o_spi_start <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_spi_bridge.md
UART_SPI_BRIDGE -- requirements
Module: uart_spi_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 43400, is the inter-byte timeout in i_clock cycles (100 bit times at 434 clocks per bit).
REQ-002 Parameter READ_FLAG, default 8'h80, is the mask ORed into the address byte for SPI reads.
REQ-003 Parameter CMD_WRITE, default 8'h57 ('W'), is the write opcode.
REQ-004 Parameter CMD_READ, default 8'h52 ('R'), is the read opcode.
REQ-005 Parameter CMD_PING, default 8'h50 ('P'), is the ping opcode.
REQ-006 Port i_clock, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-007 Port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port i_rx_dv, input, 1 bit: one-cycle strobe meaning i_rx_byte holds a valid received UART byte.
REQ-009 Port i_rx_byte, input, 8 bits: received UART byte.
REQ-010 Port o_tx_dv, output, 1 bit: one-cycle strobe that starts a UART transmit.
REQ-011 Port o_tx_byte, output, 8 bits: byte to transmit, held stable from o_tx_dv until i_tx_done.
REQ-012 Port i_tx_done, input, 1 bit: one-cycle strobe meaning the UART transmit has completed.
REQ-013 Port i_tx_active, input, 1 bit: high while the UART transmitter is busy.
REQ-014 Port o_spi_start, output, 1 bit: one-cycle strobe that starts a 16-bit SPI transaction.
REQ-015 Port o_spi_upper, output, 8 bits: SPI address byte.
REQ-016 Port o_spi_lower, output, 8 bits: SPI data byte.
REQ-017 Port i_spi_busy, input, 1 bit: high while the SPI master is busy.
REQ-018 Port i_spi_done, input, 1 bit: one-cycle strobe meaning the SPI transaction has completed.
REQ-019 Port i_spi_rx, input, 8 bits: SPI read byte, valid while i_spi_done is high.
REQ-020 Port o_busy, output, 1 bit: high in every state except IDLE.
REQ-021 Port o_err, output, 1 bit: one-cycle strobe on a protocol error.

Function
REQ-022 The state machine SHALL use the states IDLE, GET_ADDR, GET_DATA, SPI_START, SPI_WAIT, TX_START and TX_WAIT.
REQ-023 In IDLE, on i_rx_dv:
- CMD_WRITE or CMD_READ -> GET_ADDR.
- CMD_PING -> TX_START with response 8'h50.
- any other byte -> TX_START with response 8'h3F and a one-cycle o_err pulse.
REQ-024 In GET_ADDR, on i_rx_dv, the address SHALL be latched:
- write: o_spi_upper = addr & ~READ_FLAG, then -> GET_DATA.
- read: o_spi_upper = addr | READ_FLAG and o_spi_lower = 8'h00, then -> SPI_START.
REQ-025 In GET_DATA, on i_rx_dv, the block SHALL set o_spi_lower to the received byte and go to SPI_START.
REQ-026 In SPI_START, the block SHALL pulse o_spi_start for exactly one cycle, in the first cycle where i_spi_busy is low, then go to SPI_WAIT; with the SPI master idle this is the cycle after the final command byte's i_rx_dv.
REQ-027 In SPI_WAIT, on i_spi_done, the block SHALL set the response to i_spi_rx for a read or 8'h4B ('K') for a write, then go to TX_START.
REQ-028 In TX_START, the block SHALL pulse o_tx_dv for exactly one cycle, in the first cycle where i_tx_active is low, then go to TX_WAIT.
REQ-029 In TX_WAIT, on i_tx_done, the block SHALL go to IDLE.
REQ-030 An i_rx_dv received in SPI_START, SPI_WAIT, TX_START or TX_WAIT SHALL be dropped and SHALL pulse o_err; the current state is unaffected.
REQ-031 o_spi_start and o_tx_dv SHALL never be high in the same cycle.
REQ-032 Exactly one response byte SHALL be sent per completed command.

Reset
REQ-033 While i_reset is high at a clock edge, the block SHALL enter IDLE and drive o_tx_dv=0, o_spi_start=0, o_err=0, o_busy=0, o_tx_byte=8'h00, o_spi_upper=8'h00 and o_spi_lower=8'h00.
REQ-034 Reset SHALL abort any command in progress, including mid-SPI or mid-TX, and SHALL clear the timeout counter; no response is sent after reset.

Configuration
REQ-035 When UART_SPI_BRIDGE_TIMEOUT_EN is defined, a counter SHALL clear on each i_rx_dv and in IDLE, and SHALL count cycles in GET_ADDR and GET_DATA.
- Counter width SHALL be $clog2(TIMEOUT_CYCLES+1).
- When the count reaches TIMEOUT_CYCLES, the block SHALL go to IDLE, pulse o_err and send no response.
- If i_rx_dv arrives in the same cycle the count reaches TIMEOUT_CYCLES, the byte SHALL take priority and no timeout occurs.
REQ-036 When UART_SPI_BRIDGE_TIMEOUT_EN is undefined, no counter SHALL exist, and GET_ADDR and GET_DATA SHALL wait indefinitely.

Verification
REQ-037 Write: RX 57,12,A5 -> one o_spi_start with upper=12, lower=A5; after i_spi_done -> o_tx_byte=4B.
REQ-038 Read: RX 52,09 -> o_spi_start with upper=89, lower=00; i_spi_rx=3C at done -> o_tx_byte=3C.
REQ-039 Unknown opcode and ping: RX 7E -> o_err pulse and o_tx_byte=3F; RX 50 -> o_tx_byte=50.
REQ-040 Busy-drop: an extra RX byte during SPI_WAIT -> o_err pulse, the original response still sent, and no second SPI start.
REQ-041 Timeout, with the macro defined and TIMEOUT_CYCLES=100: RX 57, then 100 idle cycles -> IDLE, o_err pulse, no o_tx_dv; a byte arriving at cycle 100 -> no timeout.
REQ-042 Reset asserted during SPI_WAIT -> all outputs equal their reset values the next cycle, and no o_tx_dv follows.
